// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the inverse-cipher datapaths.
// S-box tables are packed MSB-first: entry x occupies bits [2047-8x -: 8].
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam logic [2:0] ST_NOKEY  = 3'd0;
    localparam logic [2:0] ST_KEYEXP = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic bit key_bits_legal(input int kb);
        return (kb == 128) || (kb == 192) || (kb == 256);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
                gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
                gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
                gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
    endfunction

    logic [127:0] ark_s;

    // Row r of column c takes the byte from column (c - r) mod 4, then the inverse S-box and key.
    always_comb begin
        ark_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark_s[127 - 8 * (4 * c + r) -: 8] =
                    inv_sbox(state_i[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8])
                    ^ rk_i[127 - 8 * (4 * c + r) -: 8];
            end
        end
    end

    // Column mixing, bypassed on the final round.
    always_comb begin
        state_o = ark_s;
        if (!last_i) begin
            for (int c = 0; c < 4; c++) begin
                state_o[127 - 32 * c -: 32] = inv_mix_col(ark_s[127 - 32 * c -: 32]);
            end
        end else begin
            state_o = ark_s;
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: expands the key one word per clock into a
// round-key store, then decrypts one block at a time at one round per clock.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out,
    output logic                key_loaded
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);

    if (!key_bits_legal(KEY_BITS)) begin : g_bad_key_bits
        $error("aes_inv_cipher_iter: KEY_BITS must be 128, 192 or 256");
    end

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [2:0]    kpos_q, kpos_d;
    logic [3:0]    rc_q, rc_d;
    logic [3:0]    r_q, r_d;
    logic [127:0]  st_q, st_d;
    logic [127:0]  data_out_q, data_out_d;
    logic          out_valid_q, out_valid_d;
    logic          key_loaded_q, key_loaded_d;
    logic [31:0]   w_q [NW];
    logic [31:0]   w_d [NW];

    logic [31:0]   prev_s, back_s, f_s, new_word_s;
    logic [3:0]    rk_sel_s;
    logic [IW-1:0] rk_base_s;
    logic [127:0]  rk_s, round_out_s;

    assign key_ready  = (state_q == ST_NOKEY) || (state_q == ST_IDLE);
    assign in_ready   = (state_q == ST_IDLE) && !key_valid;
    assign out_valid  = out_valid_q;
    assign data_out   = data_out_q;
    assign key_loaded = key_loaded_q;

    // Next schedule word; kpos tracks i mod NK and rc tracks i / NK.
    always_comb begin
        prev_s = w_q[i_q - IW'(1)];
        back_s = w_q[i_q - IW'(NK)];
        if (kpos_q == 3'd0) begin
            f_s = sub_word(rot_word(prev_s)) ^ {rcon(rc_q), 24'h000000};
        end else if ((NK == 8) && (kpos_q == 3'd4)) begin
            f_s = sub_word(prev_s);
        end else begin
            f_s = prev_s;
        end
        new_word_s = back_s ^ f_s;
    end

    // The initial whitening in IDLE needs RK[NR]; RUN uses the current round index.
    always_comb begin
        if (state_q == ST_IDLE) begin
            rk_sel_s = 4'(NR);
        end else begin
            rk_sel_s = r_q;
        end
        rk_base_s = IW'({rk_sel_s, 2'b00});
        rk_s = {w_q[rk_base_s], w_q[rk_base_s + IW'(1)],
                w_q[rk_base_s + IW'(2)], w_q[rk_base_s + IW'(3)]};
    end

    aes_inv_round u_round (
        .state_i (st_q),
        .rk_i    (rk_s),
        .last_i  (r_q == 4'd0),
        .state_o (round_out_s)
    );

    // Control FSM, key schedule writes and block datapath.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        kpos_d       = kpos_q;
        rc_d         = rc_q;
        r_d          = r_q;
        st_d         = st_q;
        data_out_d   = data_out_q;
        out_valid_d  = out_valid_q;
        key_loaded_d = key_loaded_q;
        w_d          = w_q;
        case (state_q)
            ST_NOKEY, ST_IDLE: begin
                if (key_valid) begin
                    for (int k = 0; k < NK; k++) begin
                        w_d[k] = key_in[KEY_BITS - 1 - 32 * k -: 32];
                    end
                    i_d          = IW'(NK);
                    kpos_d       = 3'd0;
                    rc_d         = 4'd1;
                    key_loaded_d = 1'b0;
                    state_d      = ST_KEYEXP;
                end else if (in_valid && (state_q == ST_IDLE)) begin
                    st_d    = data_in ^ rk_s;
                    r_d     = 4'(NR - 1);
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_KEYEXP: begin
                w_d[i_q] = new_word_s;
                if (i_q == IW'(NW - 1)) begin
                    key_loaded_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    i_d = i_q + IW'(1);
                end
                if (kpos_q == 3'(NK - 1)) begin
                    kpos_d = 3'd0;
                    rc_d   = rc_q + 4'd1;
                end else begin
                    kpos_d = kpos_q + 3'd1;
                end
            end
            ST_RUN: begin
                st_d = round_out_s;
                if (r_q == 4'd0) begin
                    data_out_d  = round_out_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    r_d = r_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_NOKEY;
        endcase
    end

    // Control and datapath registers; reset aborts any key expansion or block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_NOKEY;
            i_q          <= {IW{1'b0}};
            kpos_q       <= 3'd0;
            rc_q         <= 4'd0;
            r_q          <= 4'd0;
            st_q         <= 128'h0;
            data_out_q   <= 128'h0;
            out_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            kpos_q       <= kpos_d;
            rc_q         <= rc_d;
            r_q          <= r_d;
            st_q         <= st_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    // Round-key store is deliberately left unreset; key_loaded guards its contents.
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

endmodule
